// File: rtl/fp_align_pkg.sv
// fp_align_pkg: shared widths, bypass threshold and FSM state type for the alignment controller
package fp_align_pkg;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = 24;
  localparam int SEL_W    = 5;
  localparam int BYPASS_D = 24;
  typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;
endpackage

// File: rtl/fp_align_ctrl_if.sv
// fp_align_ctrl_if: operand handshake, shifter hookup and aligned-result bundle
// slave = controller side, master = operand source / shifter / consumer side
interface fp_align_ctrl_if import fp_align_pkg::*; ();
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [FRAC_W-1:0] sh_in;
  logic [SEL_W-1:0]  sh_sel;
  logic [FRAC_W-1:0] sh_out;
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  exp_out;
  logic              swap;
  logic [MANT_W-1:0] mant_big;
  logic [MANT_W-1:0] mant_small;
  modport slave (
    input  in_valid, op_a, op_b, sh_out, out_ready,
    output in_ready, sh_in, sh_sel, out_valid, exp_out, swap, mant_big, mant_small
  );
  modport master (
    output in_valid, op_a, op_b, sh_out, out_ready,
    input  in_ready, sh_in, sh_sel, out_valid, exp_out, swap, mant_big, mant_small
  );
endinterface

// File: rtl/fp_exp_cmp.sv
// fp_exp_cmp: compares exponents of two singles and splits them into larger/smaller operand fields
// ports: a_i/b_i operands; swap_o (b strictly larger), exp_big_o, d_o (exponent difference),
//        hid/frac of the larger and smaller operand
module fp_exp_cmp import fp_align_pkg::*; (
  input  logic [31:0]       a_i,
  input  logic [31:0]       b_i,
  output logic              swap_o,
  output logic [EXP_W-1:0]  exp_big_o,
  output logic [EXP_W-1:0]  d_o,
  output logic              hid_big_o,
  output logic [FRAC_W-1:0] frac_big_o,
  output logic              hid_small_o,
  output logic [FRAC_W-1:0] frac_small_o
);
  logic [EXP_W-1:0] exp_a, exp_b, exp_small;
  logic             unused_sign;
  assign unused_sign  = a_i[31] ^ b_i[31];
  assign exp_a        = a_i[30:23];
  assign exp_b        = b_i[30:23];
  // ties keep a as the larger operand
  assign swap_o       = exp_b > exp_a;
  assign exp_big_o    = swap_o ? exp_b : exp_a;
  assign exp_small    = swap_o ? exp_a : exp_b;
  assign d_o          = exp_big_o - exp_small;
  assign hid_big_o    = exp_big_o != '0;
  assign hid_small_o  = exp_small != '0;
  assign frac_big_o   = swap_o ? b_i[22:0] : a_i[22:0];
  assign frac_small_o = swap_o ? a_i[22:0] : b_i[22:0];
endmodule

// File: rtl/fp_align_ctrl.sv
// fp_align_ctrl: sequences exponent compare and external barrel-shift alignment of two singles
// ports: clk, reset (async, active-high), bus (slave side of fp_align_ctrl_if)
module fp_align_ctrl import fp_align_pkg::*; #(
  parameter int SH_LAT = 1
) (
  input logic clk,
  input logic reset,
  fp_align_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(SH_LAT + 1) + 1;
  localparam logic [SEL_W-1:0] FRAC_SEL = SEL_W'(FRAC_W);
  state_t            state_q, state_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              swap_q, swap_d, hid_q, hid_d;
  logic [MANT_W-1:0] big_q, big_d, small_q, small_d;
  logic [FRAC_W-1:0] sh_in_q, sh_in_d;
  logic [SEL_W-1:0]  sh_sel_q, sh_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              swp, hid_big, hid_small;
  logic [EXP_W-1:0]  exp_big, d;
  logic [FRAC_W-1:0] frac_big, frac_small;
  fp_exp_cmp u_cmp (
    .a_i(a_q), .b_i(b_q), .swap_o(swp), .exp_big_o(exp_big), .d_o(d),
    .hid_big_o(hid_big), .frac_big_o(frac_big), .hid_small_o(hid_small), .frac_small_o(frac_small)
  );
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    exp_d    = exp_q;
    swap_d   = swap_q;
    hid_d    = hid_q;
    big_d    = big_q;
    small_d  = small_q;
    sh_in_d  = sh_in_q;
    sh_sel_d = sh_sel_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d     = bus.op_a;
        b_d     = bus.op_b;
        state_d = CMP;
      end
      CMP: begin
        exp_d  = exp_big;
        swap_d = swp;
        big_d  = {hid_big, frac_big};
        hid_d  = hid_small;
        cnt_d  = '0;
        if (d == '0) begin
          small_d = {hid_small, frac_small};
          state_d = DONE;
        end else if (d >= EXP_W'(BYPASS_D)) begin
          small_d = '0;
          state_d = DONE;
        end else begin
          sh_in_d  = frac_small;
          sh_sel_d = d[SEL_W-1:0];
          state_d  = SHIFT;
        end
      end
      SHIFT: if (cnt_q == CNT_W'(SH_LAT)) begin
        // the shifter drops the hidden bit, so reinsert it at its shifted position
        small_d = {1'b0, bus.sh_out | (FRAC_W'(hid_q) << (FRAC_SEL - sh_sel_q))};
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      exp_q    <= '0;
      swap_q   <= 1'b0;
      hid_q    <= 1'b0;
      big_q    <= '0;
      small_q  <= '0;
      sh_in_q  <= '0;
      sh_sel_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      exp_q    <= exp_d;
      swap_q   <= swap_d;
      hid_q    <= hid_d;
      big_q    <= big_d;
      small_q  <= small_d;
      sh_in_q  <= sh_in_d;
      sh_sel_q <= sh_sel_d;
      cnt_q    <= cnt_d;
    end
  end
  assign bus.in_ready   = state_q == IDLE;
  assign bus.out_valid  = state_q == DONE;
  assign bus.exp_out    = exp_q;
  assign bus.swap       = swap_q;
  assign bus.mant_big   = big_q;
  assign bus.mant_small = small_q;
  assign bus.sh_in      = sh_in_q;
  assign bus.sh_sel     = sh_sel_q;
endmodule

// File: tb/tb_fp_align_ctrl.sv
// tb_fp_align_ctrl: table, hand-sequence and randomized checks of fp_align_ctrl against a reference model
module tb_fp_align_ctrl;
  localparam int SH_LAT = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  fp_align_ctrl_if bus ();
  fp_align_ctrl #(.SH_LAT(SH_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial bus.sh_out = '0;
  always @(posedge clk) bus.sh_out <= bus.sh_in >> bus.sh_sel;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sw;
    logic [7:0]  ex;
    logic [23:0] mb;
    logic [23:0] ms;
    int          lat;
  } vec_t;
  vec_t tbl [8];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input logic [31:0] a, input logic [31:0] b, output logic sw,
                                output logic [7:0] ex, output logic [23:0] mb, output logic [23:0] ms,
                                output int lat, output int d, output logic [22:0] fs);
    logic [31:0] bg, sm;
    logic [23:0] msm;
    sw  = b[30:23] > a[30:23];
    bg  = sw ? b : a;
    sm  = sw ? a : b;
    ex  = bg[30:23];
    mb  = {bg[30:23] != 0, bg[22:0]};
    msm = {sm[30:23] != 0, sm[22:0]};
    d   = int'(bg[30:23]) - int'(sm[30:23]);
    fs  = sm[22:0];
    ms  = d >= 24 ? 24'd0 : msm >> d;
    lat = (d == 0 || d >= 24) ? 1 : 2 + SH_LAT;
  endfunction
  task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic sw, input logic [7:0] ex,
                     input logic [23:0] mb, input logic [23:0] ms, input int lat);
    logic msw;
    logic [7:0] mex;
    logic [23:0] mmb, mms;
    logic [22:0] fs;
    logic [4:0] sel0;
    int mlat, d, k;
    model(a, b, msw, mex, mmb, mms, mlat, d, fs);
    sel0 = bus.sh_sel;
    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    tick;
    bus.in_valid = 1'b0;
    chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick;
      k++;
    end
    chk("latency", k, lat);
    chk("swap", {31'd0, bus.swap}, {31'd0, sw});
    chk("exp_out", {24'd0, bus.exp_out}, {24'd0, ex});
    chk("mant_big", {8'd0, bus.mant_big}, {8'd0, mb});
    chk("mant_small", {8'd0, bus.mant_small}, {8'd0, ms});
    if (lat == 1) chk("sh_sel_held", {27'd0, bus.sh_sel}, {27'd0, sel0});
    else begin
      chk("sh_sel", {27'd0, bus.sh_sel}, d);
      chk("sh_in", {9'd0, bus.sh_in}, {9'd0, fs});
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic sw;
    logic [7:0] ex;
    logic [23:0] mb, ms, hold_b, hold_s;
    logic [22:0] fs;
    logic [31:0] a, b;
    int lat, d, ea, eb, k, seen;
    tbl[0] = '{32'h3F800000, 32'h3F000000, 1'b0, 8'h7F, 24'h800000, 24'h400000, 3};
    tbl[1] = '{32'h40400000, 32'h40000000, 1'b0, 8'h80, 24'hC00000, 24'h800000, 1};
    tbl[2] = '{32'h3F000000, 32'h41200000, 1'b1, 8'h82, 24'hA00000, 24'h080000, 3};
    tbl[3] = '{32'h4B800000, 32'h3F800000, 1'b0, 8'h97, 24'h800000, 24'h000000, 1};
    tbl[4] = '{32'h4B000000, 32'h3F800000, 1'b0, 8'h96, 24'h800000, 24'h000001, 3};
    tbl[5] = '{32'h00400000, 32'h00200000, 1'b0, 8'h00, 24'h400000, 24'h200000, 1};
    tbl[6] = '{32'h3F800000, 32'h3FC00000, 1'b0, 8'h7F, 24'h800000, 24'hC00000, 1};
    tbl[7] = '{32'h00000000, 32'h00800000, 1'b1, 8'h01, 24'h800000, 24'h000000, 3};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    #3;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_outputs", {bus.exp_out, bus.mant_big}, 32'd0);
    chk("rst_small", {bus.sh_sel, bus.swap, 2'd0, bus.mant_small}, 32'd0);
    tick;
    reset = 1'b0;
    tick;
    for (int i = 0; i < 8; i++)
      txn(tbl[i].a, tbl[i].b, tbl[i].sw, tbl[i].ex, tbl[i].mb, tbl[i].ms, tbl[i].lat);
    // consumer stalls in DONE while a new pair is offered
    bus.in_valid = 1'b1;
    bus.op_a = 32'h3F000000;
    bus.op_b = 32'h41200000;
    tick;
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick;
      k++;
    end
    chk("stall_reach_done", {31'd0, bus.out_valid}, 32'd1);
    hold_b = bus.mant_big;
    hold_s = bus.mant_small;
    bus.op_a = 32'h40400000;
    bus.op_b = 32'h40000000;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_valid", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
      chk("stall_data", {bus.exp_out, bus.mant_big}, {8'h82, hold_b});
      chk("stall_small", {7'd0, bus.swap, bus.mant_small}, {7'd0, 1'b1, hold_s});
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk("stall_release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    tick;
    chk("stall_no_capture", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    // reset while the shifter is in use
    bus.in_valid = 1'b1;
    bus.op_a = 32'h3F800000;
    bus.op_b = 32'h3F000000;
    tick;
    bus.in_valid = 1'b0;
    tick;
    chk("mid_sh_sel", {27'd0, bus.sh_sel}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    chk("mid_rst_outs", {bus.exp_out, bus.mant_big}, 32'd0);
    chk("mid_rst_small", {bus.sh_sel, bus.swap, 2'd0, bus.mant_small}, 32'd0);
    chk("mid_rst_shin", {9'd0, bus.sh_in}, 32'd0);
    #1 reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (bus.out_valid) seen++;
    end
    chk("mid_rst_no_valid", seen, 0);
    txn(tbl[0].a, tbl[0].b, tbl[0].sw, tbl[0].ex, tbl[0].mb, tbl[0].ms, tbl[0].lat);
    for (int i = 0; i < 200; i++) begin
      ea = int'($urandom_range(0, 255));
      eb = ea + int'($urandom_range(0, 60)) - 30;
      eb = eb < 0 ? 0 : (eb > 255 ? 255 : eb);
      a = {1'($urandom), 8'(ea), 23'($urandom)};
      b = {1'($urandom), 8'(eb), 23'($urandom)};
      model(a, b, sw, ex, mb, ms, lat, d, fs);
      txn(a, b, sw, ex, mb, ms, lat);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
